hazard_fwd_ctrl: RTL and testbench

HAZARD_FWD_CTRL -- requirements
Module: hazard_fwd_ctrl

---
 rtl/hazard_fwd_ctrl.sv | 106 ++++++++++
 tb/tb_hazard_fwd_ctrl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/hazard_fwd_ctrl.sv
// Hazard and forwarding controller for a 5-stage pipeline: tracks EX/MEM destinations,
// raises a one-cycle load-use stall and registers the EX operand forwarding selects.
module hazard_fwd_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       id_rd,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             stall,
  output logic             ex_bubble,
  output logic [CNT_W-1:0] stall_count
);

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_EX  = 2'b01;
  localparam logic [1:0] SEL_MEM = 2'b10;

  logic       r_ex_valid, r_ex_rw, r_ex_mr;
  logic [4:0] r_ex_rd;
  logic       r_mem_valid, r_mem_rw, r_mem_mr;
  logic [4:0] r_mem_rd;
  logic [1:0] r_fwd_a, r_fwd_b;
  logic       r_ex_bubble;
  logic [CNT_W-1:0] r_stall_count;

  logic       w_ex_match_a, w_ex_match_b, w_mem_match_a, w_mem_match_b;
  logic [1:0] w_sel_a, w_sel_b;
  logic       w_stall, w_issue;

  // x0 is excluded here, so it can never be forwarded from either stage.
  function automatic logic producerMatch(input logic valid, input logic rw,
                                         input logic [4:0] rd, input logic [4:0] src,
                                         input logic use_src);
    return valid & rw & (rd != 5'd0) & (rd == src) & use_src;
  endfunction

  assign w_ex_match_a  = producerMatch(r_ex_valid,  r_ex_rw,  r_ex_rd,  id_rs1, id_use_rs1);
  assign w_ex_match_b  = producerMatch(r_ex_valid,  r_ex_rw,  r_ex_rd,  id_rs2, id_use_rs2);
  assign w_mem_match_a = producerMatch(r_mem_valid, r_mem_rw, r_mem_rd, id_rs1, id_use_rs1);
  assign w_mem_match_b = producerMatch(r_mem_valid, r_mem_rw, r_mem_rd, id_rs2, id_use_rs2);

  assign w_sel_a = w_ex_match_a ? SEL_EX : (w_mem_match_a ? SEL_MEM : SEL_RF);
  assign w_sel_b = w_ex_match_b ? SEL_EX : (w_mem_match_b ? SEL_MEM : SEL_RF);

  // Flush overrides a load-use hazard; reset forces stall low.
  assign w_stall = rst_n & id_valid & ~flush & r_ex_mr & (w_ex_match_a | w_ex_match_b);
  assign w_issue = id_valid & ~w_stall & ~flush;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ex_valid    <= 1'b0;
      r_ex_rw       <= 1'b0;
      r_ex_mr       <= 1'b0;
      r_ex_rd       <= 5'd0;
      r_mem_valid   <= 1'b0;
      r_mem_rw      <= 1'b0;
      r_mem_mr      <= 1'b0;
      r_mem_rd      <= 5'd0;
      r_fwd_a       <= SEL_RF;
      r_fwd_b       <= SEL_RF;
      r_ex_bubble   <= 1'b0;
      r_stall_count <= '0;
    end else begin
      r_mem_valid <= r_ex_valid;
      r_mem_rw    <= r_ex_rw;
      r_mem_mr    <= r_ex_mr;
      r_mem_rd    <= r_ex_rd;
      if (w_issue) begin
        r_ex_valid  <= 1'b1;
        r_ex_rw     <= id_reg_write;
        r_ex_mr     <= id_mem_read;
        r_ex_rd     <= id_rd;
        r_fwd_a     <= w_sel_a;
        r_fwd_b     <= w_sel_b;
        r_ex_bubble <= 1'b0;
      end else begin
        r_ex_valid  <= 1'b0;
        r_ex_rw     <= 1'b0;
        r_ex_mr     <= 1'b0;
        r_ex_rd     <= 5'd0;
        r_fwd_a     <= SEL_RF;
        r_fwd_b     <= SEL_RF;
        r_ex_bubble <= w_stall | flush;
      end
      if (w_stall && (r_stall_count != {CNT_W{1'b1}}))
        r_stall_count <= r_stall_count + 1'b1;
    end
  end

  assign fwd_a       = r_fwd_a;
  assign fwd_b       = r_fwd_b;
  assign stall       = w_stall;
  assign ex_bubble   = r_ex_bubble;
  assign stall_count = r_stall_count;

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Directed bench for hazard_fwd_ctrl using a 2-bit stall counter so saturation is reachable.
module tb_hazard_fwd_ctrl;

  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             id_valid;
  logic [4:0]       id_rs1, id_rs2, id_rd;
  logic             id_use_rs1, id_use_rs2;
  logic             id_reg_write, id_mem_read;
  logic             flush;
  logic [1:0]       fwd_a, fwd_b;
  logic             stall, ex_bubble;
  logic [CNT_W-1:0] stall_count;

  int totalChecks = 0;
  int badChecks   = 0;
  int expCount;

  hazard_fwd_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .flush(flush), .fwd_a(fwd_a), .fwd_b(fwd_b), .stall(stall),
    .ex_bubble(ex_bubble), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic v, input logic [4:0] rs1, input logic u1,
                               input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                               input logic rw, input logic mr, input logic fl);
    id_valid = v; id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
    id_rd = rd; id_reg_write = rw; id_mem_read = mr; flush = fl;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    totalChecks++;
    assert (observed === expected)
    else begin
      badChecks++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic nop();
    applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick(); tick();
    checkOutput("rst_fwd_a", fwd_a, 0);
    checkOutput("rst_fwd_b", fwd_b, 0);
    checkOutput("rst_bubble", ex_bubble, 0);
    checkOutput("rst_count", stall_count, 0);
    checkOutput("rst_stall", stall, 0);
    rst_n = 1'b1;
    nop();

    // add x5,x1,x2 ; sub x6,x5,x7
    applyStimulus(1, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0, 0);
    checkOutput("alu1_stall", stall, 0);
    tick();
    checkOutput("alu1_fwd_a", fwd_a, 0);
    applyStimulus(1, 5'd5, 1, 5'd7, 1, 5'd6, 1, 0, 0);
    checkOutput("alu2_stall", stall, 0);
    tick();
    checkOutput("b2b_fwd_a", fwd_a, 1);
    checkOutput("b2b_fwd_b", fwd_b, 0);
    nop();

    // add x5 ; nop ; or x8,x1,x5
    applyStimulus(1, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0, 0);
    tick();
    nop();
    applyStimulus(1, 5'd1, 1, 5'd5, 1, 5'd8, 1, 0, 0);
    tick();
    checkOutput("gap_fwd_a", fwd_a, 0);
    checkOutput("gap_fwd_b", fwd_b, 2);
    nop();

    // lw x5,0(x1) ; add x6,x5,x5
    applyStimulus(1, 5'd1, 1, 5'd0, 0, 5'd5, 1, 1, 0);
    tick();
    applyStimulus(1, 5'd5, 1, 5'd5, 1, 5'd6, 1, 0, 0);
    checkOutput("lu_stall_on", stall, 1);
    tick();
    checkOutput("lu_bubble", ex_bubble, 1);
    checkOutput("lu_bub_fwd_a", fwd_a, 0);
    checkOutput("lu_stall_off", stall, 0);
    tick();
    checkOutput("lu_fwd_a", fwd_a, 2);
    checkOutput("lu_fwd_b", fwd_b, 2);
    checkOutput("lu_bubble_clr", ex_bubble, 0);
    checkOutput("lu_count", stall_count, 1);
    nop();

    // add x5 ; add x5 ; add x9,x5,x0
    applyStimulus(1, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0, 0);
    tick();
    applyStimulus(1, 5'd3, 1, 5'd4, 1, 5'd5, 1, 0, 0);
    tick();
    applyStimulus(1, 5'd5, 1, 5'd0, 1, 5'd9, 1, 0, 0);
    tick();
    checkOutput("dbl_fwd_a", fwd_a, 1);
    checkOutput("dbl_fwd_b", fwd_b, 0);
    nop();

    // lw x5 ; add x6,x5,x5 with flush asserted
    applyStimulus(1, 5'd1, 1, 5'd0, 0, 5'd5, 1, 1, 0);
    tick();
    applyStimulus(1, 5'd5, 1, 5'd5, 1, 5'd6, 1, 0, 1);
    checkOutput("fl_stall", stall, 0);
    tick();
    checkOutput("fl_bubble", ex_bubble, 1);
    checkOutput("fl_count", stall_count, 1);
    nop();
    checkOutput("fl_bubble_once", ex_bubble, 0);

    // Five more load-use stalls on a 2-bit counter starting at 1
    expCount = 1;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 5'd1, 1, 5'd0, 0, 5'd5, 1, 1, 0);
      tick();
      applyStimulus(1, 5'd5, 1, 5'd2, 1, 5'd6, 1, 0, 0);
      checkOutput($sformatf("sat_stall_%0d", i), stall, 1);
      tick();
      tick();
      if (expCount < 3) expCount++;
      checkOutput($sformatf("sat_count_%0d", i), stall_count, expCount);
    end
    checkOutput("sat_final", stall_count, 3);
    nop();

    // Reset asserted while a load-use stall is pending
    applyStimulus(1, 5'd1, 1, 5'd0, 0, 5'd5, 1, 1, 0);
    tick();
    applyStimulus(1, 5'd5, 1, 5'd5, 1, 5'd6, 1, 0, 0);
    checkOutput("mid_stall_pre", stall, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_stall", stall, 0);
    tick();
    checkOutput("mid_rst_fwd_a", fwd_a, 0);
    checkOutput("mid_rst_fwd_b", fwd_b, 0);
    checkOutput("mid_rst_bubble", ex_bubble, 0);
    checkOutput("mid_rst_count", stall_count, 0);
    rst_n = 1'b1;
    #1;
    checkOutput("post_rst_stall", stall, 0);
    tick();
    checkOutput("post_rst_fwd_a", fwd_a, 0);
    checkOutput("post_rst_fwd_b", fwd_b, 0);
    checkOutput("post_rst_count", stall_count, 0);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
